// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU external bus arbiter.
// Imported by the arbiter and its testbench.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } arb_port_t;

  // A zero-length burst limit still needs a 1-bit counter.
  function automatic int burst_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Two-master arbiter for the single CPU external bus.
// Port A is the data side, port B the instruction side.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int MAX_A_BURST = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  input  logic        i_pa_rw,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic [31:0] i_pa_wdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  input  logic [31:0] i_pb_wdata
);

  localparam int CW = burst_w(MAX_A_BURST);
  localparam logic [CW-1:0] BMAX = CW'(MAX_A_BURST);

  arb_state_t      state;
  arb_port_t       last_grant;
  logic [CW-1:0]   burst_cnt;
  logic            burst_hit;
  logic            a_wins;

  assign burst_hit = (MAX_A_BURST != 0)
                   && (burst_cnt == BMAX);

  always_comb begin
    a_wins = 1'b0;
    if (i_pa_request && !i_pb_request) begin
      a_wins = 1'b1;
    end else if (i_pa_request && i_pb_request) begin
      if (ROUND_ROBIN)
        a_wins = (last_grant == PORT_B);
      else
        a_wins = !burst_hit;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      last_grant <= PORT_B;
      burst_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_pa_request || i_pb_request) begin
            if (a_wins) begin
              state <= GRANT_A;
              // Count only A grants that made B wait.
              if (!i_pb_request)
                burst_cnt <= '0;
              else if (burst_cnt != BMAX)
                burst_cnt <= burst_cnt + CW'(1);
            end else begin
              state     <= GRANT_B;
              burst_cnt <= '0;
            end
          end
        end
        GRANT_A: begin
          if (i_bus_ready) begin
            state      <= RELEASE;
            last_grant <= PORT_A;
          end else if (!i_pa_request) begin
            state <= IDLE;
          end
        end
        GRANT_B: begin
          if (i_bus_ready) begin
            state      <= RELEASE;
            last_grant <= PORT_B;
          end else if (!i_pb_request) begin
            state <= IDLE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_bus_rw      = 1'b0;
    o_bus_request = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    o_pa_ready    = 1'b0;
    o_pa_rdata    = '0;
    o_pb_ready    = 1'b0;
    o_pb_rdata    = '0;
    unique case (state)
      GRANT_A: begin
        o_bus_rw      = i_pa_rw;
        o_bus_request = i_pa_request;
        o_bus_address = i_pa_address;
        o_bus_wdata   = i_pa_wdata;
        o_pa_ready    = i_bus_ready;
        o_pa_rdata    = i_bus_rdata;
      end
      GRANT_B: begin
        o_bus_rw      = i_pb_rw;
        o_bus_request = i_pb_request;
        o_bus_address = i_pb_address;
        o_bus_wdata   = i_pb_wdata;
        o_pb_ready    = i_bus_ready;
        o_pb_rdata    = i_bus_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single CPU external bus between two masters: port A (data side, memory stage / dcache) and port B (instruction side, fetch / icache).
- Sits between the CPU pipeline bus masters and the CPU top-level bus pins.
- Grants one master at a time and holds the grant for a whole transaction, up to and including the ready cycle.
- Selects the next master either round-robin or by fixed priority to port A.

Parameters:
- ROUND_ROBIN, 1: 1 selects alternating priority when both ports are pending. 0 gives port A fixed priority.
- MAX_A_BURST, 4: used only when ROUND_ROBIN=0. After this many back-to-back port-A grants while port B is pending, port B is forced a grant. 0 disables the limit.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- o_bus_rw  out  1  to bus: 1 = write
- o_bus_request  out  1  to bus
- i_bus_ready  in  1  from bus: single-cycle completion pulse
- o_bus_address  out  32  to bus
- i_bus_rdata  in  32  from bus
- o_bus_wdata  out  32  to bus
- i_pa_rw  in  1  port A write flag
- i_pa_request  in  1  port A request
- o_pa_ready  out  1  port A completion
- i_pa_address  in  32  port A address
- o_pa_rdata  out  32  port A read data
- i_pa_wdata  in  32  port A write data
- i_pb_rw, i_pb_request, o_pb_ready, i_pb_address, o_pb_rdata, i_pb_wdata: as port A, for port B

Behaviour:
- One clock, i_clock. Reset is synchronous and active-high on i_reset.
- Master protocol:
  - A master raises request with rw, address and wdata stable.
  - It holds them until it sees ready=1.
  - It drops request in the cycle after ready; request may be low in that cycle or still visible high for one cycle.
- States (registered): IDLE, GRANT_A, GRANT_B, RELEASE.
- IDLE:
  - Only A pending: go to GRANT_A.
  - Only B pending: go to GRANT_B.
  - Both pending, ROUND_ROBIN=1: grant the port not marked in the last_grant register.
  - Both pending, ROUND_ROBIN=0: grant A, unless burst_cnt == MAX_A_BURST (nonzero limit), then grant B.
  - Arbitration latency: 1 cycle from request to o_bus_request.
- GRANT_x:
  - o_bus_* is a combinational mux of port x.
  - o_x_ready = i_bus_ready, o_x_rdata = i_bus_rdata. The other port sees ready=0 and rdata=0.
  - On i_bus_ready=1: go to RELEASE and set last_grant to x.
  - If port x drops request before ready (protocol violation): return to IDLE.
- RELEASE:
  - Exactly one cycle. o_bus_request=0 and both readies are 0.
  - Then go to IDLE.
  - This absorbs the master's one-cycle-late request drop, so the same transaction is never issued twice.
  - Minimum spacing between bus transactions is 2 cycles.
- burst_cnt (width clog2(MAX_A_BURST+1)):
  - Increments on each A grant while B is pending, saturating.
  - Clears on any B grant, or on an A grant with B idle.
- Outside GRANT states, all o_bus_* outputs are 0.
- i_bus_ready in IDLE or RELEASE is ignored and not forwarded.
- Reset, including mid-transaction: state=IDLE, last_grant=B (so A wins the first round-robin contention), burst_cnt=0.
  - From the cycle after the reset edge: o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_pa_ready=o_pb_ready=0, o_pa_rdata=o_pb_rdata=0.
- Address and data pass through unmodified; no byte lanes and no width conversion.

Decomposition:
- Shared CPU defines package:
  - arb_state_t enum (IDLE, GRANT_A, GRANT_B, RELEASE).
  - arb_port_t (PORT_A, PORT_B).
- Single module; no sub-module. The output mux is inline combinational logic.

Test Plan:
- Single A read:
  - Stimulus: A requests 0x2000_0010; bus returns ready with rdata 0xDEADBEEF at cycle 3.
  - Required: o_bus_request high from cycle 1; o_pa_ready=1 with rdata 0xDEADBEEF in cycle 3; bus request low in cycle 4 (RELEASE); o_pb_ready=0 throughout.
- Contention, round-robin:
  - Stimulus: A and B both request continuously, each bus transaction taking 2 cycles.
  - Required: grants alternate A, B, A, B, starting with A after reset; no two bus requests are adjacent without a RELEASE cycle between them.
- Fixed priority with burst limit:
  - Stimulus: ROUND_ROBIN=0, MAX_A_BURST=2; A and B request continuously.
  - Required: grant order A, A, B, A, A, B.
- Write passthrough:
  - Stimulus: B writes 0x1234_5678 to 0x0000_0100.
  - Required: while granted, o_bus_rw=1, address 0x0000_0100, wdata 0x1234_5678; port A sees ready=0.
- Reset mid-transaction:
  - Stimulus: i_reset asserted in GRANT_A before ready arrives.
  - Required: the next cycle shows all outputs 0 and state IDLE; a subsequent B-only request is granted 1 cycle after reset deasserts.
- Late request drop:
  - Stimulus: master keeps request high for one cycle after ready.
  - Required: exactly one bus transaction is observed; no duplicate grant.
